// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC select (exception > redirect > interrupt > stall > sequential), IF/ID register, EPC and interrupt pending.
// One-cycle ROM-to-IF/ID latency; stall holds PC and IF/ID, but an exception or a redirect still overrides it.
module fetch_unit #(
    parameter logic [31:0] RESET_VEC = 32'h00000000,
    parameter logic [31:0] IRQ_VEC   = 32'h80000004,
    parameter logic [31:0] EXC_VEC   = 32'h80000008,
    parameter logic [31:0] NOP_WORD  = 32'h00000000,
    parameter logic [31:0] EPC_ADJ   = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redir_en,
    input  logic [31:0] redir_pc,
    input  logic        exc_req,
    input  logic        irq,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] pc,
    output logic        kernel,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pcp4,
    output logic [31:0] epc,
    output logic        irq_taken,
    output logic        exc_taken
);

    logic        irq_pending;
    logic        take_exc;
    logic        take_irq;
    logic [31:0] pc_p4;

    always_comb begin
        take_exc = exc_req && ifid_valid;
        take_irq = irq_pending && !kernel && !stall && !take_exc && !redir_en;
        pc_p4    = pc + 32'd4;
    end

    assign kernel    = pc[31];
    assign imem_addr = {1'b0, pc[30:0]};
    assign ifid_pcp4 = ifid_pc + 32'd4;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= RESET_VEC;
            ifid_valid  <= 1'b0;
            ifid_instr  <= NOP_WORD;
            ifid_pc     <= 32'd0;
            epc         <= 32'd0;
            irq_pending <= 1'b0;
            irq_taken   <= 1'b0;
            exc_taken   <= 1'b0;
        end else begin
            irq_taken <= 1'b0;
            exc_taken <= 1'b0;
            if (take_exc) begin
                pc         <= EXC_VEC;
                epc        <= ifid_pc + EPC_ADJ;
                ifid_valid <= 1'b0;
                ifid_instr <= NOP_WORD;
                exc_taken  <= 1'b1;
            end else if (redir_en) begin
                pc         <= redir_pc;
                ifid_valid <= 1'b0;
                ifid_instr <= NOP_WORD;
            end else if (take_irq) begin
                // The word fetched at pc is dropped, so pc itself is the return address.
                pc         <= IRQ_VEC;
                epc        <= pc;
                ifid_valid <= 1'b0;
                ifid_instr <= NOP_WORD;
                irq_taken  <= 1'b1;
            end else if (!stall) begin
                pc         <= pc_p4;
                ifid_valid <= 1'b1;
                ifid_instr <= imem_data;
                ifid_pc    <= pc;
            end

            // Kernel mode masks rather than queues; entering a handler also drops it.
            if (kernel || take_exc || take_irq)
                irq_pending <= 1'b0;
            else if (irq)
                irq_pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redir_en;
    logic [31:0] redir_pc;
    logic        exc_req;
    logic        irq;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] pc;
    logic        kernel;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pcp4;
    logic [31:0] epc;
    logic        irq_taken;
    logic        exc_taken;

    int checks = 0;
    int errors = 0;

    fetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .redir_en   (redir_en),
        .redir_pc   (redir_pc),
        .exc_req    (exc_req),
        .irq        (irq),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .pc         (pc),
        .kernel     (kernel),
        .ifid_valid (ifid_valid),
        .ifid_instr (ifid_instr),
        .ifid_pc    (ifid_pc),
        .ifid_pcp4  (ifid_pcp4),
        .epc        (epc),
        .irq_taken  (irq_taken),
        .exc_taken  (exc_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: a real instruction at 0, otherwise an address-tagged word.
    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a == 32'd0) ? 32'h20080001 : (32'hAC000000 | a);
    endfunction
    assign imem_data = rom(imem_addr);

    typedef struct {
        logic        st;
        logic        re;
        logic [31:0] rpc;
        logic        ex;
        logic        iq;
        logic [31:0] e_pc;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
        logic [31:0] e_epc;
        logic        e_it;
        logic        e_et;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic st, input logic re, input logic [31:0] rpc,
                                input logic ex, input logic iq, input logic [31:0] e_pc,
                                input logic e_valid, input logic [31:0] e_instr,
                                input logic [31:0] e_ipc, input logic [31:0] e_epc,
                                input logic e_it, input logic e_et);
        vec_t v;
        v.st = st; v.re = re; v.rpc = rpc; v.ex = ex; v.iq = iq;
        v.e_pc = e_pc; v.e_valid = e_valid; v.e_instr = e_instr;
        v.e_ipc = e_ipc; v.e_epc = e_epc; v.e_it = e_it; v.e_et = e_et;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic e_valid,
                           input logic [31:0] e_instr, input logic [31:0] e_ipc,
                           input logic [31:0] e_epc, input logic e_it, input logic e_et);
        logic [31:0] e_addr;
        e_addr = {1'b0, e_pc[30:0]};
        chk({tag, ".pc"},         pc,                 e_pc);
        chk({tag, ".kernel"},     {31'd0, kernel},    {31'd0, e_pc[31]});
        chk({tag, ".imem_addr"},  imem_addr,          e_addr);
        chk({tag, ".ifid_valid"}, {31'd0, ifid_valid}, {31'd0, e_valid});
        chk({tag, ".ifid_instr"}, ifid_instr,         e_instr);
        chk({tag, ".ifid_pc"},    ifid_pc,            e_ipc);
        chk({tag, ".ifid_pcp4"},  ifid_pcp4,          e_ipc + 32'd4);
        chk({tag, ".epc"},        epc,                e_epc);
        chk({tag, ".irq_taken"},  {31'd0, irq_taken}, {31'd0, e_it});
        chk({tag, ".exc_taken"},  {31'd0, exc_taken}, {31'd0, e_et});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic re, input logic [31:0] rpc,
                         input logic ex, input logic iq);
        stall = st; redir_en = re; redir_pc = rpc; exc_req = ex; irq = iq;
    endtask

    initial begin
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        reset = 1'b0;

        //          st re rpc            ex iq  pc             v  instr          ifid_pc        epc            it et
        vq.push_back(mk(0, 0, 32'h0,        0, 0, 32'h00000004, 1, 32'h20080001, 32'h00000000, 32'h00000000, 0, 0));
        vq.push_back(mk(0, 0, 32'h0,        0, 0, 32'h00000008, 1, 32'hAC000004, 32'h00000004, 32'h00000000, 0, 0));
        vq.push_back(mk(1, 0, 32'h0,        0, 0, 32'h00000008, 1, 32'hAC000004, 32'h00000004, 32'h00000000, 0, 0));
        vq.push_back(mk(1, 0, 32'h0,        0, 0, 32'h00000008, 1, 32'hAC000004, 32'h00000004, 32'h00000000, 0, 0));
        vq.push_back(mk(1, 0, 32'h0,        0, 0, 32'h00000008, 1, 32'hAC000004, 32'h00000004, 32'h00000000, 0, 0));
        vq.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0000000C, 1, 32'hAC000008, 32'h00000008, 32'h00000000, 0, 0));
        vq.push_back(mk(1, 1, 32'h100,      0, 0, 32'h00000100, 0, 32'h00000000, 32'h00000008, 32'h00000000, 0, 0));
        vq.push_back(mk(0, 1, 32'h40,       0, 0, 32'h00000040, 0, 32'h00000000, 32'h00000008, 32'h00000000, 0, 0));
        vq.push_back(mk(0, 0, 32'h0,        0, 1, 32'h00000044, 1, 32'hAC000040, 32'h00000040, 32'h00000000, 0, 0));
        vq.push_back(mk(0, 0, 32'h0,        0, 0, 32'h80000004, 0, 32'h00000000, 32'h00000040, 32'h00000044, 1, 0));
        vq.push_back(mk(0, 0, 32'h0,        0, 1, 32'h80000008, 1, 32'hAC000004, 32'h80000004, 32'h00000044, 0, 0));
        vq.push_back(mk(0, 0, 32'h0,        0, 1, 32'h8000000C, 1, 32'hAC000008, 32'h80000008, 32'h00000044, 0, 0));
        vq.push_back(mk(0, 1, 32'h44,       0, 1, 32'h00000044, 0, 32'h00000000, 32'h80000008, 32'h00000044, 0, 0));
        vq.push_back(mk(0, 0, 32'h0,        0, 0, 32'h00000048, 1, 32'hAC000044, 32'h00000044, 32'h00000044, 0, 0));
        vq.push_back(mk(0, 0, 32'h0,        0, 1, 32'h0000004C, 1, 32'hAC000048, 32'h00000048, 32'h00000044, 0, 0));
        vq.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0000004C, 1, 32'hAC000048, 32'h00000048, 32'h00000044, 0, 0));
        vq.push_back(mk(0, 0, 32'h0,        0, 0, 32'h80000004, 0, 32'h00000000, 32'h00000048, 32'h0000004C, 1, 0));
        vq.push_back(mk(0, 1, 32'h20,       0, 0, 32'h00000020, 0, 32'h00000000, 32'h00000048, 32'h0000004C, 0, 0));
        vq.push_back(mk(0, 0, 32'h0,        0, 1, 32'h00000024, 1, 32'hAC000020, 32'h00000020, 32'h0000004C, 0, 0));
        vq.push_back(mk(0, 1, 32'h300,      1, 1, 32'h80000008, 0, 32'h00000000, 32'h00000020, 32'h00000020, 0, 1));
        vq.push_back(mk(0, 0, 32'h0,        0, 0, 32'h8000000C, 1, 32'hAC000008, 32'h80000008, 32'h00000020, 0, 0));
        vq.push_back(mk(0, 1, 32'h60,       0, 0, 32'h00000060, 0, 32'h00000000, 32'h80000008, 32'h00000020, 0, 0));
        vq.push_back(mk(0, 0, 32'h0,        0, 0, 32'h00000064, 1, 32'hAC000060, 32'h00000060, 32'h00000020, 0, 0));
        vq.push_back(mk(0, 1, 32'h70,       0, 0, 32'h00000070, 0, 32'h00000000, 32'h00000060, 32'h00000020, 0, 0));
        vq.push_back(mk(0, 0, 32'h0,        1, 0, 32'h00000074, 1, 32'hAC000070, 32'h00000070, 32'h00000020, 0, 0));
        vq.push_back(mk(0, 1, 32'hFFFFFFFC, 0, 0, 32'hFFFFFFFC, 0, 32'h00000000, 32'h00000070, 32'h00000020, 0, 0));
        vq.push_back(mk(0, 0, 32'h0,        0, 0, 32'h00000000, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h00000020, 0, 0));
        vq.push_back(mk(0, 1, 32'h80000010, 0, 0, 32'h80000010, 0, 32'h00000000, 32'hFFFFFFFC, 32'h00000020, 0, 0));
        vq.push_back(mk(0, 0, 32'h0,        0, 0, 32'h80000014, 1, 32'hAC000010, 32'h80000010, 32'h00000020, 0, 0));
        vq.push_back(mk(0, 0, 32'h0,        1, 0, 32'h80000008, 0, 32'h00000000, 32'h80000010, 32'h80000010, 0, 1));

        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        #3 reset = 1'b1;

        foreach (vq[i]) begin
            drive(vq[i].st, vq[i].re, vq[i].rpc, vq[i].ex, vq[i].iq);
            step();
            chk_all($sformatf("vec%0d", i), vq[i].e_pc, vq[i].e_valid, vq[i].e_instr,
                    vq[i].e_ipc, vq[i].e_epc, vq[i].e_it, vq[i].e_et);
        end

        // Asynchronous reset during a stall+redirect with an interrupt pending.
        drive(1'b0, 1'b1, 32'h200, 1'b0, 1'b0);
        step();
        chk("pre_rst.pc", pc, 32'h00000200);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step();
        chk("pre_rst.pc2", pc, 32'h00000204);
        drive(1'b1, 1'b1, 32'h500, 1'b0, 1'b0);
        #3 reset = 1'b0;
        #1;
        chk_all("async_rst", 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        chk_all("rst_held", 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        #3 reset = 1'b1;
        step();
        chk_all("post_rst1", 32'h4, 1'b1, 32'h20080001, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        chk_all("post_rst2", 32'h8, 1'b1, 32'hAC000004, 32'h4, 32'h0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
